// File: rtl/wb_mon_pkg.sv
// Shared codes for the Wishbone transaction monitor: CTI/BTE encodings,
// monitor FSM states and violation flag bit positions.
package wb_mon_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } mon_state_e;

  localparam int NUM_ERR        = 5;
  localparam int ERR_TERM_NOSEL = 0;
  localparam int ERR_MULTI_TERM = 1;
  localparam int ERR_BURST_ADR  = 2;
  localparam int ERR_ATTR_CHG   = 3;
  localparam int ERR_CYC_DROP   = 4;

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next expected address of an incrementing burst: +1 word, wrapping inside a
// 4/8/16-word aligned window for the wrap BTE codes.
module wb_burst_addr_gen
  import wb_mon_pkg::*;
#(
  parameter int ADR_W = 32
) (
  input  logic [ADR_W-1:0] adr,
  input  logic [1:0]       bte,
  output logic [ADR_W-1:0] next_adr
);

  logic [ADR_W-1:0] inc_adr;
  logic [ADR_W-1:0] step_mask;

  assign inc_adr = adr + ADR_W'(4);

  // Bits under the mask take the incremented value; the rest hold, which pins the wrap window.
  always_comb begin
    step_mask = '1;
    case (bte)
      BTE_LINEAR: step_mask = '1;
      BTE_WRAP4:  step_mask = ADR_W'(6'h0F);
      BTE_WRAP8:  step_mask = ADR_W'(6'h1F);
      BTE_WRAP16: step_mask = ADR_W'(6'h3F);
      default:    step_mask = '1;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ADR_W; gi++) begin : g_bit
      assign next_adr[gi] = step_mask[gi] ? inc_adr[gi] : adr[gi];
    end
  endgenerate

endmodule

// File: rtl/wb_txn_monitor.sv
// Passive Wishbone checker: follows classic/incrementing bursts, counts beats and
// bursts, raises sticky violation flags with a trigger pulse, and spots repeated read data.
module wb_txn_monitor
  import wb_mon_pkg::*;
#(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic               mon_cyc,
  input  logic               mon_stb,
  input  logic               mon_we,
  input  logic [ADR_W-1:0]   mon_adr,
  input  logic [2:0]         mon_cti,
  input  logic [1:0]         mon_bte,
  input  logic [DAT_W-1:0]   mon_dat_r,
  input  logic               mon_ack,
  input  logic               mon_err,
  input  logic               mon_rty,
  input  logic               clr,
  output logic [NUM_ERR-1:0] err_flags,
  output logic               trig,
  output logic               dup,
  output logic [CNT_W-1:0]   beat_cnt,
  output logic [CNT_W-1:0]   burst_cnt
);

  mon_state_e         state_reg, state_next;
  logic [ADR_W-1:0]   exp_adr_reg, exp_adr_next;
  logic               we_reg, we_next;
  logic [1:0]         bte_reg, bte_next;
  logic [NUM_ERR-1:0] flags_reg, flags_next;
  logic               trig_reg, trig_next;
  logic               dup_reg, dup_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic               hist_valid_reg, hist_valid_next;
  logic [DAT_W-1:0]   hist_dat_reg, hist_dat_next;

  logic               bus_sel, term_any, term_multi, beat, ack_beat, rd_ack_beat;
  logic [NUM_ERR-1:0] viol, flags_set;
  logic               burst_done;
  logic [ADR_W-1:0]   gen_adr_in, gen_adr_out;
  logic [1:0]         gen_bte_in;

  assign bus_sel     = mon_cyc & mon_stb;
  assign term_any    = mon_ack | mon_err | mon_rty;
  assign term_multi  = (mon_ack & mon_err) | (mon_ack & mon_rty) | (mon_err & mon_rty);
  assign beat        = bus_sel & term_any;
  assign ack_beat    = beat & mon_ack & ~term_multi;
  assign rd_ack_beat = ack_beat & ~mon_we;

  // Burst start steps from the bus address; inside a burst, from the tracked expectation.
  assign gen_adr_in = (state_reg == ST_BURST) ? exp_adr_reg : mon_adr;
  assign gen_bte_in = (state_reg == ST_BURST) ? bte_reg : mon_bte;

  wb_burst_addr_gen #(.ADR_W(ADR_W)) u_addr_gen (
    .adr      (gen_adr_in),
    .bte      (gen_bte_in),
    .next_adr (gen_adr_out)
  );

  always_comb begin
    state_next   = state_reg;
    exp_adr_next = exp_adr_reg;
    we_next      = we_reg;
    bte_next     = bte_reg;
    burst_done   = 1'b0;
    viol         = '0;
    viol[ERR_TERM_NOSEL] = term_any & ~bus_sel;
    viol[ERR_MULTI_TERM] = term_multi;
    case (state_reg)
      ST_IDLE: begin
        if (ack_beat && mon_cti == CTI_INCR) begin
          state_next   = ST_BURST;
          exp_adr_next = gen_adr_out;
          we_next      = mon_we;
          bte_next     = mon_bte;
        end
      end
      ST_BURST: begin
        if (!mon_cyc) begin
          state_next         = ST_IDLE;
          viol[ERR_CYC_DROP] = 1'b1;
        end else if (beat) begin
          viol[ERR_BURST_ADR] = (mon_adr != exp_adr_reg);
          viol[ERR_ATTR_CHG]  = (mon_we != we_reg) | (mon_bte != bte_reg);
          // err/rty terminates the burst quietly; only a clean ack can continue or close it
          if (!ack_beat) begin
            state_next = ST_IDLE;
          end else begin
            case (mon_cti)
              CTI_INCR:    exp_adr_next = gen_adr_out;
              CTI_END: begin
                state_next = ST_IDLE;
                burst_done = 1'b1;
              end
              CTI_CLASSIC: state_next = ST_IDLE;
              default:     state_next = ST_IDLE;
            endcase
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ERR; gi++) begin : g_flag
      assign flags_set[gi] = viol[gi] & ~flags_reg[gi];
    end
  endgenerate

  always_comb begin
    flags_next      = flags_reg | viol;
    trig_next       = |flags_set;
    dup_next        = rd_ack_beat & hist_valid_reg & (mon_dat_r == hist_dat_reg);
    hist_valid_next = hist_valid_reg;
    hist_dat_next   = hist_dat_reg;
    beat_cnt_next   = beat_cnt_reg;
    burst_cnt_next  = burst_cnt_reg;
    if (rd_ack_beat) begin
      hist_valid_next = 1'b1;
      hist_dat_next   = mon_dat_r;
    end
    if (beat && beat_cnt_reg != '1)
      beat_cnt_next = beat_cnt_reg + CNT_W'(1);
    if (burst_done && burst_cnt_reg != '1)
      burst_cnt_next = burst_cnt_reg + CNT_W'(1);
    if (clr) begin
      flags_next      = '0;
      trig_next       = 1'b0;
      dup_next        = 1'b0;
      hist_valid_next = 1'b0;
      beat_cnt_next   = '0;
      burst_cnt_next  = '0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg   <= ST_IDLE;
      exp_adr_reg <= '0;
      we_reg      <= 1'b0;
      bte_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      exp_adr_reg <= exp_adr_next;
      we_reg      <= we_next;
      bte_reg     <= bte_next;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      flags_reg      <= '0;
      trig_reg       <= 1'b0;
      dup_reg        <= 1'b0;
      beat_cnt_reg   <= '0;
      burst_cnt_reg  <= '0;
      hist_valid_reg <= 1'b0;
      hist_dat_reg   <= '0;
    end else begin
      flags_reg      <= flags_next;
      trig_reg       <= trig_next;
      dup_reg        <= dup_next;
      beat_cnt_reg   <= beat_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      hist_valid_reg <= hist_valid_next;
      hist_dat_reg   <= hist_dat_next;
    end
  end

  assign err_flags = flags_reg;
  assign trig      = trig_reg;
  assign dup       = dup_reg;
  assign beat_cnt  = beat_cnt_reg;
  assign burst_cnt = burst_cnt_reg;

endmodule

// File: tb/tb_wb_txn_monitor.sv
// Directed and randomized Wishbone traffic for wb_txn_monitor, checked every cycle
// against a transaction-level reference model.
module tb_wb_txn_monitor;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int CNT_W = 16;

  logic             wb_clk = 1'b0;
  logic             wb_rst_n = 1'b0;
  logic             mon_cyc = 1'b0, mon_stb = 1'b0, mon_we = 1'b0;
  logic [ADR_W-1:0] mon_adr = '0;
  logic [2:0]       mon_cti = '0;
  logic [1:0]       mon_bte = '0;
  logic [DAT_W-1:0] mon_dat_r = '0;
  logic             mon_ack = 1'b0, mon_err = 1'b0, mon_rty = 1'b0;
  logic             clr = 1'b0;
  logic [4:0]       err_flags;
  logic             trig, dup;
  logic [CNT_W-1:0] beat_cnt, burst_cnt;

  always #5 wb_clk = ~wb_clk;

  wb_txn_monitor #(.ADR_W(ADR_W), .DAT_W(DAT_W), .CNT_W(CNT_W)) dut (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .mon_cyc   (mon_cyc),
    .mon_stb   (mon_stb),
    .mon_we    (mon_we),
    .mon_adr   (mon_adr),
    .mon_cti   (mon_cti),
    .mon_bte   (mon_bte),
    .mon_dat_r (mon_dat_r),
    .mon_ack   (mon_ack),
    .mon_err   (mon_err),
    .mon_rty   (mon_rty),
    .clr       (clr),
    .err_flags (err_flags),
    .trig      (trig),
    .dup       (dup),
    .beat_cnt  (beat_cnt),
    .burst_cnt (burst_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of the bus
  bit          m_in_burst;
  logic [31:0] m_exp;
  bit          m_we;
  logic [1:0]  m_bte;
  logic [4:0]  m_flags;
  bit          m_trig, m_dup;
  int          m_beats, m_bursts;
  bit          m_hist_ok;
  logic [31:0] m_hist;

  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
    int unsigned n, idx, base;
    if (bte == 2'd0) return a + 32'd4;
    n    = 4 << (bte - 1);
    idx  = a >> 2;
    base = idx - (idx % n);
    return 32'(((base + ((idx + 1) % n)) << 2)) | (a & 32'h3);
  endfunction

  task automatic model_reset();
    m_in_burst = 0; m_exp = '0; m_we = 0; m_bte = '0;
    m_flags = '0; m_trig = 0; m_dup = 0; m_beats = 0; m_bursts = 0;
    m_hist_ok = 0; m_hist = '0;
  endtask

  task automatic model_step();
    int   nterm;
    bit   sel, beat, clean_ack, done;
    logic [4:0] v;
    nterm     = int'(mon_ack) + int'(mon_err) + int'(mon_rty);
    sel       = mon_cyc && mon_stb;
    beat      = sel && (nterm > 0);
    clean_ack = beat && mon_ack && (nterm == 1);
    done      = 0;
    v         = '0;
    if (nterm > 0 && !sel) v[0] = 1'b1;
    if (nterm > 1) v[1] = 1'b1;
    if (m_in_burst) begin
      if (!mon_cyc) begin
        v[4] = 1'b1;
        m_in_burst = 0;
      end else if (beat) begin
        if (mon_adr != m_exp) v[2] = 1'b1;
        if (mon_we != m_we || mon_bte != m_bte) v[3] = 1'b1;
        if (clean_ack && mon_cti == 3'b010) m_exp = next_adr(m_exp, m_bte);
        else begin
          m_in_burst = 0;
          done = clean_ack && (mon_cti == 3'b111);
        end
      end
    end else if (clean_ack && mon_cti == 3'b010) begin
      m_in_burst = 1;
      m_we  = mon_we;
      m_bte = mon_bte;
      m_exp = next_adr(mon_adr, mon_bte);
    end
    if (clr) begin
      m_flags = '0; m_trig = 0; m_dup = 0; m_beats = 0; m_bursts = 0; m_hist_ok = 0;
    end else begin
      m_trig  = |(v & ~m_flags);
      m_flags = m_flags | v;
      m_dup   = clean_ack && !mon_we && m_hist_ok && (mon_dat_r == m_hist);
      if (clean_ack && !mon_we) begin
        m_hist_ok = 1;
        m_hist    = mon_dat_r;
      end
      if (beat && m_beats < 65535) m_beats++;
      if (done && m_bursts < 65535) m_bursts++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag, input bit chk);
    model_step();
    @(posedge wb_clk);
    #1;
    if (chk) begin
      check({tag, ".flags"}, 32'(err_flags), 32'(m_flags));
      check({tag, ".trig"},  32'(trig),      32'(m_trig));
      check({tag, ".dup"},   32'(dup),       32'(m_dup));
      check({tag, ".beats"}, 32'(beat_cnt),  32'(m_beats));
      check({tag, ".bursts"},32'(burst_cnt), 32'(m_bursts));
    end
  endtask

  task automatic drive(input bit c, input bit s, input bit w, input logic [31:0] a,
                       input logic [2:0] ct, input logic [1:0] bt,
                       input bit ak, input bit er, input bit rt, input logic [31:0] d);
    mon_cyc = c; mon_stb = s; mon_we = w; mon_adr = a; mon_cti = ct; mon_bte = bt;
    mon_ack = ak; mon_err = er; mon_rty = rt; mon_dat_r = d;
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 0, '0, 3'b000, 2'b00, 0, 0, 0, '0);
    tick(tag, 1);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  ct;
    logic [1:0]  bt;
    bit          w, ak, er, rt, dropped;
    int          len;

    model_reset();
    repeat (2) @(posedge wb_clk);
    #1;
    check("reset.flags",  32'(err_flags), 32'h0);
    check("reset.trig",   32'(trig),      32'h0);
    check("reset.beats",  32'(beat_cnt),  32'h0);
    check("reset.bursts", 32'(burst_cnt), 32'h0);
    wb_rst_n = 1'b1;
    idle("start");
    $display("step reset: outputs idle");

    // 4-beat linear read burst
    drive(1, 1, 0, 32'h100, 3'b010, 2'b00, 1, 0, 0, 32'h11); tick("lin0", 1);
    drive(1, 1, 0, 32'h104, 3'b010, 2'b00, 1, 0, 0, 32'h22); tick("lin1", 1);
    drive(1, 1, 0, 32'h108, 3'b010, 2'b00, 1, 0, 0, 32'h33); tick("lin2", 1);
    drive(1, 1, 0, 32'h10C, 3'b111, 2'b00, 1, 0, 0, 32'h44); tick("lin3", 1);
    check("lin.burst_cnt", 32'(burst_cnt), 32'd1);
    check("lin.beat_cnt",  32'(beat_cnt),  32'd4);
    check("lin.flags",     32'(err_flags), 32'd0);
    idle("lin_idle");
    $display("step linear burst: beats=%0d bursts=%0d flags=%b", beat_cnt, burst_cnt, err_flags);

    // Wrap-4 burst from 0x10C, then a bad address
    drive(1, 1, 0, 32'h10C, 3'b010, 2'b01, 1, 0, 0, 32'h55); tick("wrap0", 1);
    drive(1, 1, 0, 32'h100, 3'b010, 2'b01, 1, 0, 0, 32'h66); tick("wrap1", 1);
    drive(1, 1, 0, 32'h104, 3'b010, 2'b01, 1, 0, 0, 32'h77); tick("wrap2", 1);
    check("wrap.clean", 32'(err_flags), 32'd0);
    drive(1, 1, 0, 32'h110, 3'b010, 2'b01, 1, 0, 0, 32'h88); tick("wrap3", 1);
    check("wrap.flag2", 32'(err_flags), 32'h04);
    check("wrap.trig",  32'(trig),      32'h1);
    drive(1, 1, 0, 32'h10C, 3'b111, 2'b01, 1, 0, 0, 32'h99); tick("wrap4", 1);
    check("wrap.trig_once", 32'(trig), 32'h0);
    idle("wrap_idle");
    $display("step wrap4 burst: flags=%b bursts=%0d", err_flags, burst_cnt);

    // clr, ack without stb, clr again; clr also swallows a same-cycle violation
    clr = 1; idle("clr0"); clr = 0;
    drive(1, 0, 0, 32'h0, 3'b000, 2'b00, 1, 0, 0, 32'h0); tick("nostb", 1);
    check("nostb.flag0", 32'(err_flags), 32'h01);
    check("nostb.trig",  32'(trig),      32'h1);
    idle("nostb_idle");
    check("nostb.trig_off", 32'(trig), 32'h0);
    drive(0, 0, 0, 32'h0, 3'b000, 2'b00, 1, 0, 0, 32'h0);
    clr = 1; tick("clr_evt", 1); clr = 0;
    check("clr.flags", 32'(err_flags), 32'h0);
    check("clr.trig",  32'(trig),      32'h0);
    idle("clr_idle");
    $display("step clr: flags=%b trig=%0b", err_flags, trig);

    // Duplicate read data with a write in between
    drive(1, 1, 0, 32'h40, 3'b000, 2'b00, 1, 0, 0, 32'hDEADBEEF); tick("dup0", 1);
    check("dup.first", 32'(dup), 32'h0);
    drive(1, 1, 1, 32'h44, 3'b000, 2'b00, 1, 0, 0, 32'h12345678); tick("dup_wr", 1);
    drive(1, 1, 0, 32'h48, 3'b000, 2'b00, 1, 0, 0, 32'hDEADBEEF); tick("dup1", 1);
    check("dup.second", 32'(dup), 32'h1);
    idle("dup_idle");
    check("dup.pulse", 32'(dup), 32'h0);
    $display("step dup: beats=%0d", beat_cnt);

    // cyc dropped after two burst beats
    drive(1, 1, 0, 32'h200, 3'b010, 2'b00, 1, 0, 0, 32'h1); tick("drop0", 1);
    drive(1, 1, 0, 32'h204, 3'b010, 2'b00, 1, 0, 0, 32'h2); tick("drop1", 1);
    idle("drop2");
    check("drop.flag4",  32'(err_flags[4]), 32'h1);
    check("drop.bursts", 32'(burst_cnt),    32'h0);
    drive(1, 1, 0, 32'h300, 3'b111, 2'b00, 1, 0, 0, 32'h3); tick("drop_idle_end", 1);
    check("drop.idle_end", 32'(burst_cnt), 32'h0);
    idle("drop_idle");
    $display("step cyc drop: flags=%b bursts=%0d", err_flags, burst_cnt);

    // Randomized bursts with occasional faults
    for (int t = 0; t < 60; t++) begin
      len = $urandom_range(1, 6);
      bt  = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      a   = 32'h1000 + 32'($urandom_range(0, 63) << 2);
      dropped = 0;
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) begin
          drive(1, 1, w, a, 3'b010, bt, 0, 0, 0, 32'h0);
          tick("rnd_wait", 1);
        end
        ak = 1; er = 0; rt = 0;
        case ($urandom_range(0, 99)) inside
          [0:4]:   begin ak = 0; er = 1; end
          [5:7]:   begin ak = 0; rt = 1; end
          [8:9]:   er = 1;
          default: ;
        endcase
        ct = (len == 1) ? 3'b000 : ((b == len - 1) ? 3'b111 : 3'b010);
        drive(1, 1, w, ($urandom_range(0, 99) < 8) ? a + 32'h20 : a, ct,
              ($urandom_range(0, 99) < 4) ? ~bt : bt, ak, er, rt,
              ($urandom_range(0, 99) < 40) ? 32'hA5A5A5A5 : 32'($urandom));
        clr = ($urandom_range(0, 99) < 3);
        tick("rnd_beat", 1);
        clr = 0;
        a = next_adr(a, bt);
        if (b == 1 && $urandom_range(0, 99) < 10) begin
          dropped = 1;
          break;
        end
      end
      idle("rnd_idle");
      if ($urandom_range(0, 99) < 5) begin
        drive(1, 0, 0, '0, 3'b000, 2'b00, 1, 0, 0, '0);
        tick("rnd_glitch", 1);
        idle("rnd_glitch_idle");
      end
      $display("txn %0d len=%0d bte=%0d we=%0d drop=%0d beats=%0d bursts=%0d flags=%b",
               t, len, bt, w, dropped, beat_cnt, burst_cnt, err_flags);
    end

    // Beat counter saturation
    clr = 1; idle("sat_clr"); clr = 0;
    for (int i = 0; i < 65540; i++) begin
      drive(1, 1, 1, 32'h0, 3'b000, 2'b00, 1, 0, 0, 32'h0);
      tick("sat", 0);
    end
    idle("sat_end");
    check("sat.beat_cnt", 32'(beat_cnt), 32'h0000FFFF);
    $display("step saturation: beats=%0h", beat_cnt);

    // Reset in the middle of a burst, then continuation treated as a fresh burst
    drive(1, 1, 0, 32'h300, 3'b010, 2'b00, 1, 0, 0, 32'h5); tick("rb0", 1);
    drive(1, 1, 0, 32'h304, 3'b010, 2'b00, 1, 0, 0, 32'h6); tick("rb1", 1);
    wb_rst_n = 1'b0;
    #1;
    check("rstmid.flags",  32'(err_flags), 32'h0);
    check("rstmid.trig",   32'(trig),      32'h0);
    check("rstmid.dup",    32'(dup),       32'h0);
    check("rstmid.beats",  32'(beat_cnt),  32'h0);
    check("rstmid.bursts", 32'(burst_cnt), 32'h0);
    @(posedge wb_clk);
    #1;
    wb_rst_n = 1'b1;
    model_reset();
    drive(1, 1, 0, 32'h308, 3'b010, 2'b00, 1, 0, 0, 32'h7); tick("rb2", 1);
    drive(1, 1, 0, 32'h30C, 3'b111, 2'b00, 1, 0, 0, 32'h8); tick("rb3", 1);
    check("rstmid.fresh_flags",  32'(err_flags), 32'h0);
    check("rstmid.fresh_bursts", 32'(burst_cnt), 32'h1);
    idle("rb_idle");
    $display("step reset mid-burst: beats=%0d bursts=%0d flags=%b", beat_cnt, burst_cnt, err_flags);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
